// File: rtl/cpu_phase_seq.sv
// cpu_phase_seq
//   One-hot instruction-cycle phase register for the CPU control path.
//   Phase 0 is the fetch/restart phase. The phase moves on prioritised
//   requests or on sequential auto-advance, and can be frozen by a stall.
//   All state changes on the falling edge of CLK.
//
// Parameters
//   NPH   number of phases (>= 2)
//   CNTW  width of the dwell counter
//   IDXW  width of IDX (>= clog2(NPH))
//
// Ports
//   CLK    in   clock, state updates on the falling edge
//   RST    in   asynchronous reset, active-high
//   REQ    in   [NPH-1:0] phase request vector, lower index has priority
//   ADV    in   advance to the next phase index (wraps to 0)
//   STALL  in   freeze phase and dwell counter (REQ[0] still honoured)
//   PH     out  [NPH-1:0] current phase, one-hot
//   IDX    out  [IDXW-1:0] binary index of the current phase
//   ENTER  out  high for the cycle following any phase load
//   DWELL  out  [CNTW-1:0] edges spent in current phase, saturating
//   ERR    out  sticky flag: PH was found not one-hot and was recovered
module cpu_phase_seq #(
  parameter int NPH  = 4,
  parameter int CNTW = 8,
  parameter int IDXW = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NPH-1:0]  REQ,
  input  logic            ADV,
  input  logic            STALL,
  output logic [NPH-1:0]  PH,
  output logic [IDXW-1:0] IDX,
  output logic            ENTER,
  output logic [CNTW-1:0] DWELL,
  output logic            ERR
);

  logic [NPH-1:0]  ph_q, ph_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            enter_q, enter_d;
  logic [CNTW-1:0] dwell_q, dwell_d;
  logic            err_q, err_d;

  logic            ph_onehot;
  logic            req_hi_any;
  logic [IDXW-1:0] req_lo_idx;
  logic [IDXW-1:0] idx_next;
  logic            load;
  logic [IDXW-1:0] target;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign ph_onehot = (ph_q != '0) && ((ph_q & (ph_q - NPH'(1))) == '0);

  assign req_hi_any = |REQ[NPH-1:1];

  // Lowest set request index among REQ[NPH-1:1]; scanning downward lets the
  // lowest index overwrite any higher one.
  always_comb begin
    req_lo_idx = '0;
    for (int i = NPH - 1; i >= 1; i--) begin
      if (REQ[i]) begin
        req_lo_idx = IDXW'(i);
      end
    end
  end

  assign idx_next = (idx_q == IDXW'(NPH - 1)) ? '0 : idx_q + IDXW'(1);

  always_comb begin
    ph_d    = ph_q;
    idx_d   = idx_q;
    enter_d = 1'b0;
    dwell_d = dwell_q;
    err_d   = err_q;
    load    = 1'b0;
    target  = '0;

    if (!ph_onehot) begin
      // Corrupted phase register: restart from fetch and flag it.
      load   = 1'b1;
      target = '0;
      err_d  = 1'b1;
    end else if (REQ[0]) begin
      load   = 1'b1;
      target = '0;
    end else if (STALL) begin
      // Hold phase and dwell; ENTER already defaults low.
    end else if (req_hi_any) begin
      load   = 1'b1;
      target = req_lo_idx;
    end else if (ADV) begin
      load   = 1'b1;
      target = idx_next;
    end else if (dwell_q != '1) begin
      dwell_d = dwell_q + CNTW'(1);
    end

    // Every load re-enters, even when the target is the current phase.
    if (load) begin
      ph_d    = NPH'(1) << target;
      idx_d   = target;
      enter_d = 1'b1;
      dwell_d = '0;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      ph_q    <= NPH'(1);
      idx_q   <= '0;
      enter_q <= 1'b0;
      dwell_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      enter_q <= enter_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
    end
  end

  assign PH    = ph_q;
  assign IDX   = idx_q;
  assign ENTER = enter_q;
  assign DWELL = dwell_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_cpu_phase_seq.sv
module tb_cpu_phase_seq;

  localparam int NPH  = 4;
  localparam int CNTW = 3;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NPH-1:0]  req;
  logic            adv;
  logic            stall;
  logic [NPH-1:0]  ph;
  logic [IDXW-1:0] idx;
  logic            enter;
  logic [CNTW-1:0] dwell;
  logic            err;

  cpu_phase_seq #(.NPH(NPH), .CNTW(CNTW), .IDXW(IDXW)) dut (
    .CLK  (clk),
    .RST  (rst),
    .REQ  (req),
    .ADV  (adv),
    .STALL(stall),
    .PH   (ph),
    .IDX  (idx),
    .ENTER(enter),
    .DWELL(dwell),
    .ERR  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NPH-1:0]  req;
    logic            adv;
    logic            stall;
    logic [NPH-1:0]  ph;
    logic [IDXW-1:0] idx;
    logic            enter;
    logic [CNTW-1:0] dwell;
    logic            err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [NPH-1:0] r, input logic a, input logic s,
                              input logic [NPH-1:0] p, input logic [IDXW-1:0] i,
                              input logic e, input logic [CNTW-1:0] d, input logic er);
    vec_t v;
    v.req = r; v.adv = a; v.stall = s;
    v.ph = p; v.idx = i; v.enter = e; v.dwell = d; v.err = er;
    return v;
  endfunction

  // Drive one vector away from the falling edge, queue its expectation,
  // then compare once the falling edge has updated the outputs.
  task automatic drive(input vec_t v);
    vec_t e;
    @(posedge clk);
    req = v.req; adv = v.adv; stall = v.stall;
    exp_q.push_back(v);
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    txn++;
    $display("txn %0d req=%b adv=%b stall=%b -> ph=%b idx=%0d enter=%b dwell=%0d err=%b",
             txn, v.req, v.adv, v.stall, ph, idx, enter, dwell, err);
    chk("ph",    32'(ph),    32'(e.ph));
    chk("idx",   32'(idx),   32'(e.idx));
    chk("enter", 32'(enter), 32'(e.enter));
    chk("dwell", 32'(dwell), 32'(e.dwell));
    chk("err",   32'(err),   32'(e.err));
  endtask

  initial begin
    rst = 1'b1; req = '0; adv = 1'b0; stall = 1'b0;

    // Vector table, applied from phase 0 right after reset.
    vecs.push_back(mk(4'b1110, 0, 0, 4'b0010, 1, 1, 0, 0)); // lowest request wins
    vecs.push_back(mk(4'b1001, 0, 1, 4'b0001, 0, 1, 0, 0)); // REQ[0] beats stall
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0010, 1, 1, 0, 0)); // advance x5
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0100, 2, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b1000, 3, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0010, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 4'b0100, 2, 1, 0, 0)); // request beats advance
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0100, 2, 0, 1, 0)); // idle
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(4'b1000, 0, 1, 4'b0100, 2, 0, 1, 0)); // stall holds
    vecs.push_back(mk(4'b0000, 1, 1, 4'b0100, 2, 0, 1, 0)); // stall beats advance
    vecs.push_back(mk(4'b0100, 0, 0, 4'b0100, 2, 1, 0, 0)); // re-entry
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(4'b0000, 0, 0, 4'b0100, 2, 0, 3'((k > 7) ? 7 : k), 0));
    vecs.push_back(mk(4'b0100, 0, 0, 4'b0100, 2, 1, 0, 0)); // re-entry after saturation
    vecs.push_back(mk(4'b0110, 0, 0, 4'b0010, 1, 1, 0, 0));
    vecs.push_back(mk(4'b1000, 0, 0, 4'b1000, 3, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0001, 0, 1, 0, 0)); // wrap 3 -> 0

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ph",    32'(ph),    32'h1);
    chk("rst_idx",   32'(idx),   32'h0);
    chk("rst_enter", 32'(enter), 32'h0);
    chk("rst_dwell", 32'(dwell), 32'h0);
    chk("rst_err",   32'(err),   32'h0);
    @(posedge clk);
    rst = 1'b0;

    foreach (vecs[i]) drive(vecs[i]);

    // Corruption: hold a two-hot PH across one falling edge.
    @(posedge clk);
    req = '0; adv = 1'b0; stall = 1'b0;
    force dut.ph_q = 4'b0110;
    @(negedge clk);
    #1;
    chk("corr_err",   32'(err),   32'h1);
    chk("corr_enter", 32'(enter), 32'h1);
    chk("corr_idx",   32'(idx),   32'h0);
    release dut.ph_q;
    @(negedge clk);
    #1;
    chk("corr_ph",   32'(ph),  32'h1);
    chk("corr_idx2", 32'(idx), 32'h0);
    chk("corr_err2", 32'(err), 32'h1);

    // ERR stays set through later phase changes.
    drive(mk(4'b0000, 1, 0, 4'b0010, 1, 1, 0, 1));
    drive(mk(4'b1000, 0, 0, 4'b1000, 3, 1, 0, 1));
    drive(mk(4'b0000, 0, 0, 4'b1000, 3, 0, 1, 1));

    // Asynchronous reset mid-run: outputs clear before any falling edge.
    @(posedge clk);
    req = '0; adv = 1'b0; stall = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ph",    32'(ph),    32'h1);
    chk("mid_rst_idx",   32'(idx),   32'h0);
    chk("mid_rst_enter", 32'(enter), 32'h0);
    chk("mid_rst_dwell", 32'(dwell), 32'h0);
    chk("mid_rst_err",   32'(err),   32'h0);
    @(negedge clk);
    @(posedge clk);
    rst = 1'b0;

    // First edge after reset follows normal rules from phase 0.
    drive(mk(4'b0000, 1, 0, 4'b0010, 1, 1, 0, 0));
    drive(mk(4'b0000, 0, 0, 4'b0010, 1, 0, 1, 0));

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d leftover expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
